pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_pkg.sv | 23 ++
 rtl/pipe_stage_skid_sat_counter.sv | 35 +++
 rtl/pipe_stage_skid.sv | 100 ++++++++++
 tb/tb_pipe_stage_skid.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared types for valid/ready pipeline stage registers: skid FSM states and
// the occupancy encoding reported to the CPU tracker.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd1;
    localparam logic [1:0] OCC_SKID  = 2'd2;

    function automatic logic [1:0] occ_of(skid_state_t s);
        case (s)
            FULL:    return OCC_FULL;
            SKID:    return OCC_SKID;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear; shared by the perf counters.
// Clear wins over increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer so in_ready
// is a pure function of state; supports flush and counts back-pressure cycles.
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             drain;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != SKID);
    assign occupancy = occ_of(state_q);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready & ~flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d = SKID;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (out_valid & ~out_ready & ~flush),
        .clr   (stat_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (payload cleared / held on flush)
// driven in lockstep and compared against a queue-based behavioural model.
module tb_pipe_stage_skid;

    localparam int W   = 8;
    localparam int CW  = 3;
    localparam int SAT = 7;

    logic          CLK = 1'b0;
    logic          RST;
    logic          flush, in_valid, out_ready, stat_clr;
    logic [W-1:0]  in_data;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [W-1:0]  out_data0, out_data1;
    logic [1:0]    occ0, occ1;
    logic [CW-1:0] stall0, stall1;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] last0, last1;
    int           cnt_m;
    logic         m_acc;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) dut0 (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0), .stat_clr(stat_clr), .stall_cnt(stall0));

    pipe_stage_skid #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) dut1 (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1), .stat_clr(stat_clr), .stall_cnt(stall1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        last0 = '0;
        last1 = '0;
        cnt_m = 0;
        m_acc = 1'b0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        bit oval, acc, drn;
        logic [W-1:0] popped;
        oval = (q.size() > 0);
        acc  = in_valid && (q.size() < 2) && !flush;
        drn  = oval && out_ready && !flush;
        m_acc = acc;
        if (stat_clr)                              cnt_m = 0;
        else if (oval && !out_ready && !flush && cnt_m < SAT) cnt_m++;
        if (flush) begin
            last0 = '0;
            if (q.size() > 0) last1 = q[0];
            q.delete();
        end else begin
            if (drn) begin
                popped = q.pop_front();
                if (q.size() == 0) begin
                    last0 = popped;
                    last1 = popped;
                end
            end
            if (acc) q.push_back(in_data);
        end
    endfunction

    task automatic check_all(input string tag);
        logic [W-1:0] e0, e1;
        e0 = (q.size() > 0) ? q[0] : last0;
        e1 = (q.size() > 0) ? q[0] : last1;
        chk({tag, ".out_valid0"}, 32'(out_valid0), 32'(q.size() > 0));
        chk({tag, ".out_valid1"}, 32'(out_valid1), 32'(q.size() > 0));
        chk({tag, ".in_ready0"},  32'(in_ready0),  32'(q.size() < 2));
        chk({tag, ".in_ready1"},  32'(in_ready1),  32'(q.size() < 2));
        chk({tag, ".occ0"},       32'(occ0),       32'(q.size()));
        chk({tag, ".occ1"},       32'(occ1),       32'(q.size()));
        chk({tag, ".out_data0"},  32'(out_data0),  32'(e0));
        chk({tag, ".out_data1"},  32'(out_data1),  32'(e1));
        chk({tag, ".stall0"},     32'(stall0),     32'(cnt_m));
        chk({tag, ".stall1"},     32'(stall1),     32'(cnt_m));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic         held;
        logic         ir;
        RST = 1'b1; flush = 0; in_valid = 0; out_ready = 0; stat_clr = 0; in_data = '0;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_all("reset_release");

        // Pass-through at full throughput
        out_ready = 1; in_valid = 1;
        in_data = 8'h01; step("pt1"); chk("pt1.data", 32'(out_data0), 32'h01); chk("pt1.occ", 32'(occ0), 1);
        in_data = 8'h02; step("pt2"); chk("pt2.data", 32'(out_data0), 32'h02); chk("pt2.occ", 32'(occ0), 1);
        in_data = 8'h03; step("pt3"); chk("pt3.data", 32'(out_data0), 32'h03); chk("pt3.stall", 32'(stall0), 0);
        in_valid = 0; step("pt_idle");

        // Back-pressure into the skid slot
        out_ready = 0; in_valid = 1;
        in_data = 8'hA1; step("bp1"); chk("bp1.in_ready", 32'(in_ready0), 1);
        in_data = 8'hA2; step("bp2"); chk("bp2.in_ready", 32'(in_ready0), 0); chk("bp2.occ", 32'(occ0), 2);
        in_data = 8'hA3; step("bp3"); chk("bp3.data", 32'(out_data0), 32'hA1);
        out_ready = 1;   step("bp4"); chk("bp4.data", 32'(out_data0), 32'hA2);
        step("bp5"); chk("bp5.data", 32'(out_data0), 32'hA3);
        in_valid = 0; step("bp6"); chk("bp6.valid", 32'(out_valid0), 0);
        stat_clr = 1; step("bp_clr"); stat_clr = 0;

        // Flush while two beats are held
        out_ready = 0; in_valid = 1;
        in_data = 8'h11; step("fl1");
        in_data = 8'h22; step("fl2"); chk("fl2.occ", 32'(occ0), 2);
        flush = 1; in_data = 8'h33; step("fl3");
        flush = 0; in_valid = 0;
        chk("fl3.valid", 32'(out_valid0), 0);
        chk("fl3.in_ready", 32'(in_ready0), 1);
        chk("fl3.data_clr", 32'(out_data0), 32'h00);
        chk("fl3.data_hold", 32'(out_data1), 32'h11);
        out_ready = 1;
        repeat (3) begin
            step("fl_after");
            chk("fl_after.valid", 32'(out_valid0), 0);
        end

        // Saturating stall counter
        out_ready = 0; in_valid = 1; in_data = 8'h55; stat_clr = 1; step("st0");
        in_valid = 0; stat_clr = 0;
        for (int i = 0; i < 10; i++) begin
            step("st");
            chk("st.cnt", 32'(stall0), (i + 1 < SAT) ? i + 1 : SAT);
        end
        stat_clr = 1; step("st_clr"); chk("st_clr.cnt", 32'(stall0), 0);
        stat_clr = 0; flush = 1; step("st_flush"); flush = 0;

        // Asynchronous reset between clock edges
        in_valid = 1;
        in_data = 8'h61; step("ar1");
        in_data = 8'h62; step("ar2"); chk("ar2.occ", 32'(occ0), 2);
        in_valid = 0;
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.valid", 32'(out_valid0), 0);
        chk("async_rst.in_ready", 32'(in_ready0), 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        out_ready = 1; in_valid = 1; in_data = 8'h77;
        step("ar_first"); chk("ar_first.data", 32'(out_data0), 32'h77);
        in_valid = 0; step("ar_idle");

        // Randomised traffic against the model
        held = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!held) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = W'($urandom);
            end
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 32) == 0;
            stat_clr  = ($urandom % 64) == 0;
            if ((c % 16) == 0) begin
                ir = in_ready0;
                out_ready = ~out_ready;
                #1;
                chk("rnd.in_ready_comb", 32'(in_ready0), 32'(ir));
                out_ready = ~out_ready;
            end
            step("rnd");
            held = in_valid && !m_acc && !flush;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
